// File: rtl/irq_arbiter.sv
// Interrupt arbiter: captures rising edges from peripheral interrupt lines into
// pending bits, masks them with a per-source enable, and presents the lowest-index
// winner to the core with a claim/complete handshake over a small register file.
module irq_arbiter #(
    parameter int unsigned NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_src_i,
    input  logic [31:0]        data_i,
    input  logic [31:0]        addr_i,
    input  logic               we_i,
    input  logic               re_i,
    output logic [31:0]        data_o,
    output logic               irq_o,
    output logic [4:0]         irq_id_o
);

    typedef enum logic [1:0] {StIdle, StAssert, StService} state_e;

    localparam logic [3:0] OffPending  = 4'h0;
    localparam logic [3:0] OffEnable   = 4'h4;
    localparam logic [3:0] OffClaim    = 4'h8;
    localparam logic [3:0] OffComplete = 4'hC;

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] src_q;
    logic               armed_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [4:0]         active_q, active_d;
    logic               irq_q, irq_d;
    logic [4:0]         irq_id_q, irq_id_d;

    logic [3:0]         offset;
    logic [NUM_SRC-1:0] masked;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] winner_oh;
    logic [4:0]         winner_id;
    logic               claim_fire;
    logic               complete_fire;
    logic               unused_bits;

    assign offset      = addr_i[3:0];
    assign masked      = pending_q & enable_q;
    assign unused_bits = ^{addr_i[31:4], data_i};

    // armed_q stays low for the first edge after reset so lines already high at
    // release are treated as a stale level rather than a fresh edge.
    assign rise = irq_src_i & ~src_q & {NUM_SRC{armed_q}};

    assign claim_fire    = re_i && (offset == OffClaim) && (winner_id != 5'd0);
    assign complete_fire = we_i && (offset == OffComplete) && (state_q == StService) &&
                           (data_i[4:0] == active_q);

    // Fixed-priority pick: lowest index among pending & enabled sources.
    always_comb begin
        winner_id = 5'd0;
        winner_oh = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (masked[i]) begin
                winner_id    = 5'(i + 1);
                winner_oh    = '0;
                winner_oh[i] = 1'b1;
            end
        end
    end

    // Register file next state: set beats clear on a same-cycle edge and claim.
    always_comb begin
        pending_d = (pending_q & ~(claim_fire ? winner_oh : '0)) | rise;
        enable_d  = enable_q;
        active_d  = active_q;
        if (we_i && (offset == OffEnable)) begin
            enable_d = data_i[NUM_SRC-1:0];
        end
        if (claim_fire) begin
            active_d = winner_id;
        end
    end

    // Request FSM next state and registered request outputs.
    always_comb begin
        state_d  = state_q;
        irq_d    = 1'b0;
        irq_id_d = 5'd0;
        unique case (state_q)
            StIdle: begin
                if (claim_fire) begin
                    state_d = StService;
                end else if (winner_id != 5'd0) begin
                    state_d  = StAssert;
                    irq_d    = 1'b1;
                    irq_id_d = winner_id;
                end
            end
            StAssert: begin
                if (claim_fire) begin
                    state_d = StService;
                end else if (winner_id == 5'd0) begin
                    state_d = StIdle;
                end else begin
                    irq_d    = 1'b1;
                    irq_id_d = winner_id;
                end
            end
            StService: begin
                if (claim_fire) begin
                    state_d = StService;
                end else if (complete_fire) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // All state registers share the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            src_q     <= '0;
            armed_q   <= 1'b0;
            pending_q <= '0;
            enable_q  <= '0;
            active_q  <= 5'd0;
            irq_q     <= 1'b0;
            irq_id_q  <= 5'd0;
        end else begin
            state_q   <= state_d;
            src_q     <= irq_src_i;
            armed_q   <= 1'b1;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            active_q  <= active_d;
            irq_q     <= irq_d;
            irq_id_q  <= irq_id_d;
        end
    end

    // Bus read mux; every source register is zero in reset so data_o is too.
    always_comb begin
        data_o = 32'd0;
        case (offset)
            OffPending:  data_o[NUM_SRC-1:0] = pending_q;
            OffEnable:   data_o[NUM_SRC-1:0] = enable_q;
            OffClaim:    data_o[4:0]         = winner_id;
            OffComplete: data_o[4:0]         = active_q;
            default:     data_o              = 32'd0;
        endcase
    end

    assign irq_o    = irq_q;
    assign irq_id_o = irq_id_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_irq_arbiter;

    localparam int N = 8;
    localparam int M_IDLE = 0;
    localparam int M_ASSERT = 1;
    localparam int M_SERV = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  irq_src_i;
    logic [31:0]   data_i;
    logic [31:0]   addr_i;
    logic          we_i;
    logic          re_i;
    logic [31:0]   data_o;
    logic          irq_o;
    logic [4:0]    irq_id_o;

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit [N-1:0] m_pend, m_en, m_prev;
    bit         m_armed;
    int         m_state;
    bit         m_irq;
    bit [4:0]   m_id, m_active;

    irq_arbiter #(.NUM_SRC(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_src_i (irq_src_i),
        .data_i    (data_i),
        .addr_i    (addr_i),
        .we_i      (we_i),
        .re_i      (re_i),
        .data_o    (data_o),
        .irq_o     (irq_o),
        .irq_id_o  (irq_id_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int m_winner();
        for (int i = 0; i < N; i++) begin
            if (m_pend[i] && m_en[i]) return i + 1;
        end
        return 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] off);
        logic [31:0] r;
        r = 32'd0;
        if (off == 4'h0) r = 32'(m_pend);
        else if (off == 4'h4) r = 32'(m_en);
        else if (off == 4'h8) r = 32'(m_winner());
        else if (off == 4'hC) r = 32'(m_active);
        return r;
    endfunction

    task automatic m_reset();
        m_pend = '0; m_en = '0; m_prev = '0; m_armed = 1'b0;
        m_state = M_IDLE; m_irq = 1'b0; m_id = 5'd0; m_active = 5'd0;
    endtask

    task automatic m_step(input bit [N-1:0] src, input bit we, input bit re,
                          input logic [3:0] off, input logic [31:0] d);
        int w;
        bit claim, comp;
        bit [N-1:0] np;
        w = m_winner();
        claim = re && (off == 4'h8) && (w != 0);
        comp = we && (off == 4'hC) && (m_state == M_SERV) && (d[4:0] == m_active);
        for (int i = 0; i < N; i++) begin
            np[i] = m_pend[i];
            if (claim && (i == w - 1)) np[i] = 1'b0;
            if (m_armed && src[i] && !m_prev[i]) np[i] = 1'b1;
        end
        m_pend = np;
        if (we && (off == 4'h4)) m_en = d[N-1:0];
        m_irq = 1'b0;
        m_id = 5'd0;
        if (m_state == M_IDLE) begin
            if (claim) m_state = M_SERV;
            else if (w != 0) begin m_state = M_ASSERT; m_irq = 1'b1; m_id = 5'(w); end
        end else if (m_state == M_ASSERT) begin
            if (claim) m_state = M_SERV;
            else if (w == 0) m_state = M_IDLE;
            else begin m_irq = 1'b1; m_id = 5'(w); end
        end else begin
            if (!claim && comp) m_state = M_IDLE;
        end
        if (claim) m_active = 5'(w);
        m_prev = src;
        m_armed = 1'b1;
    endtask

    // One bus cycle: drive, check combinational read, clock, check registered outputs.
    task automatic cycle(input logic [N-1:0] src, input logic we, input logic re,
                         input logic [31:0] addr, input logic [31:0] d, input string tag);
        irq_src_i = src; we_i = we; re_i = re; addr_i = addr; data_i = d;
        #1;
        check_eq({tag, "_rd"}, data_o, m_read(addr[3:0]));
        @(posedge clk);
        m_step(src, we, re, addr[3:0], d);
        #1;
        check_eq({tag, "_irq"}, 32'(irq_o), 32'(m_irq));
        check_eq({tag, "_id"}, 32'(irq_id_o), 32'(m_id));
    endtask

    task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        addr_i = addr; we_i = 1'b0; re_i = 1'b0;
        #1;
        check_eq(tag, data_o, exp);
    endtask

    initial begin
        logic [N-1:0] src;
        logic [3:0]   nib;
        logic [31:0]  d;
        logic         we, re;

        rst_n = 1'b0; irq_src_i = '0; data_i = '0; addr_i = '0; we_i = 1'b0; re_i = 1'b0;
        m_reset();
        #22;
        check_eq("rst_irq", 32'(irq_o), 32'd0);
        check_eq("rst_id", 32'(irq_id_o), 32'd0);
        check_eq("rst_data", data_o, 32'd0);
        rst_n = 1'b1;
        cycle('0, 1'b0, 1'b0, 32'h0, 32'h0, "post_rst");

        // 1: single source, one-cycle latency to irq_o
        cycle(8'h00, 1'b1, 1'b0, 32'h4, 32'h1, "t1_en");
        cycle(8'h01, 1'b0, 1'b0, 32'h0, 32'h0, "t1_edge");
        read_chk("t1_pend", 32'h0, 32'h1);
        check_eq("t1_irq_k", 32'(irq_o), 32'd0);
        cycle(8'h00, 1'b0, 1'b0, 32'h0, 32'h0, "t1_k1");
        check_eq("t1_irq_k1", 32'(irq_o), 32'd1);
        check_eq("t1_id_k1", 32'(irq_id_o), 32'd1);
        cycle(8'h00, 1'b0, 1'b1, 32'h8, 32'h0, "t1_claim");
        cycle(8'h00, 1'b1, 1'b0, 32'hC, 32'h1, "t1_done");

        // 2: higher priority arrival replaces the presented ID
        cycle(8'h00, 1'b1, 1'b0, 32'h4, 32'h3, "t2_en");
        cycle(8'h02, 1'b0, 1'b0, 32'h0, 32'h0, "t2_s1");
        cycle(8'h02, 1'b0, 1'b0, 32'h0, 32'h0, "t2_a1");
        check_eq("t2_id2", 32'(irq_id_o), 32'd2);
        cycle(8'h03, 1'b0, 1'b0, 32'h0, 32'h0, "t2_s0");
        cycle(8'h03, 1'b0, 1'b0, 32'h0, 32'h0, "t2_a0");
        check_eq("t2_id1", 32'(irq_id_o), 32'd1);
        read_chk("t2_claim_val", 32'h8, 32'h1);
        cycle(8'h03, 1'b0, 1'b1, 32'h8, 32'h0, "t2_claim");
        read_chk("t2_pend", 32'h0, 32'h2);
        check_eq("t2_irq_srv", 32'(irq_o), 32'd0);

        // 3: wrong COMPLETE ignored, right one re-arbitrates a cycle later
        cycle(8'h03, 1'b1, 1'b0, 32'hC, 32'h2, "t3_bad");
        check_eq("t3_irq_bad", 32'(irq_o), 32'd0);
        read_chk("t3_active", 32'hC, 32'h1);
        cycle(8'h03, 1'b1, 1'b0, 32'hC, 32'h1, "t3_good");
        check_eq("t3_irq_good", 32'(irq_o), 32'd0);
        cycle(8'h03, 1'b0, 1'b0, 32'h0, 32'h0, "t3_re");
        check_eq("t3_irq_re", 32'(irq_o), 32'd1);
        check_eq("t3_id_re", 32'(irq_id_o), 32'd2);

        // 4: held level does not re-request; a fresh edge does
        cycle(8'h03, 1'b0, 1'b1, 32'h8, 32'h0, "t4_claim");
        cycle(8'h03, 1'b1, 1'b0, 32'hC, 32'h2, "t4_done");
        for (int i = 0; i < 3; i++) begin
            cycle(8'h03, 1'b0, 1'b0, 32'h0, 32'h0, "t4_hold");
            check_eq("t4_no_irq", 32'(irq_o), 32'd0);
        end
        cycle(8'h02, 1'b0, 1'b0, 32'h0, 32'h0, "t4_drop");
        cycle(8'h03, 1'b0, 1'b0, 32'h0, 32'h0, "t4_rise");
        cycle(8'h03, 1'b0, 1'b0, 32'h0, 32'h0, "t4_req");
        check_eq("t4_id_new", 32'(irq_id_o), 32'd1);
        cycle(8'h03, 1'b0, 1'b1, 32'h8, 32'h0, "t4_claim2");
        cycle(8'h03, 1'b1, 1'b0, 32'hC, 32'h1, "t4_done2");

        // 5: edge in the same cycle as the clearing claim keeps pending set
        cycle(8'h02, 1'b0, 1'b0, 32'h0, 32'h0, "t5_drop");
        cycle(8'h03, 1'b0, 1'b0, 32'h0, 32'h0, "t5_rise");
        cycle(8'h02, 1'b0, 1'b0, 32'h0, 32'h0, "t5_drop2");
        cycle(8'h03, 1'b0, 1'b1, 32'h8, 32'h0, "t5_claim");
        read_chk("t5_pend", 32'h0, 32'h1);
        check_eq("t5_irq", 32'(irq_o), 32'd0);
        cycle(8'h03, 1'b1, 1'b0, 32'hC, 32'h1, "t5_done");
        cycle(8'h03, 1'b0, 1'b0, 32'h0, 32'h0, "t5_re");
        check_eq("t5_id_re", 32'(irq_id_o), 32'd1);

        // 6: asynchronous reset in SERVICE
        cycle(8'h03, 1'b0, 1'b1, 32'h8, 32'h0, "t6_claim");
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_irq", 32'(irq_o), 32'd0);
        check_eq("t6_id", 32'(irq_id_o), 32'd0);
        read_chk("t6_pend", 32'h0, 32'h0);
        read_chk("t6_en", 32'h4, 32'h0);
        m_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cycle(8'h03, 1'b1, 1'b0, 32'h4, 32'h1, "t6_en1");
        for (int i = 0; i < 3; i++) begin
            cycle(8'h03, 1'b0, 1'b0, 32'h0, 32'h0, "t6_held");
            check_eq("t6_no_irq", 32'(irq_o), 32'd0);
        end
        read_chk("t6_pend_held", 32'h0, 32'h0);
        cycle(8'h02, 1'b0, 1'b0, 32'h0, 32'h0, "t6_drop");
        cycle(8'h03, 1'b0, 1'b0, 32'h0, 32'h0, "t6_rise");
        cycle(8'h03, 1'b0, 1'b0, 32'h0, 32'h0, "t6_req");
        check_eq("t6_irq_new", 32'(irq_o), 32'd1);

        // Random traffic against the model
        src = 8'h03;
        for (int k = 0; k < 1500; k++) begin
            src = src ^ N'($urandom & $urandom & $urandom);
            we = ($urandom_range(0, 3) == 0);
            re = (m_state != M_SERV) && ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 4))
                0: nib = 4'h0;
                1: nib = 4'h4;
                2: nib = 4'h8;
                3: nib = 4'hC;
                default: nib = 4'($urandom);
            endcase
            d = $urandom;
            if (nib == 4'hC && $urandom_range(0, 1) == 1) d = 32'(m_active);
            cycle(src, we, re, {$urandom, nib} >> 0, d, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
